// File: rtl/spi_ram.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram
//  Purpose  : Command-decoding single-port RAM behind an SPI slave. It accepts
//             one 10-bit frame per rx_valid level and performs an address
//             load, a data write, or a data read.
//  Revision : 1.0
// ============================================================================
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam logic [1:0]           c_CMD_WR_ADDR = 2'b00;
    localparam logic [1:0]           c_CMD_WR_DATA = 2'b01;
    localparam logic [1:0]           c_CMD_RD_ADDR = 2'b10;
    localparam logic [1:0]           c_CMD_RD_DATA = 2'b11;
    localparam logic [8:0]           c_DEPTH       = 9'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] c_LAST_ADDR   = ADDR_SIZE'(MEM_DEPTH - 1);

    logic                 r_rx_valid_d;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_vld;
    logic                 r_rd_vld;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;
    logic                 r_cmd_err;
    logic [7:0]           r_mem [MEM_DEPTH];

    logic                 w_accept;
    logic [1:0]           w_cmd;
    logic [7:0]           w_payload;
    logic                 w_addr_ok;
    logic                 w_do_write;
    logic                 w_do_read;
    logic [ADDR_SIZE-1:0] w_wr_addr_inc;
    logic [ADDR_SIZE-1:0] w_rd_addr_inc;

    // One accept per rising edge of the rx_valid level.
    assign w_accept   = rx_valid & ~r_rx_valid_d;
    assign w_cmd      = din[9:8];
    assign w_payload  = din[7:0];
    assign w_addr_ok  = {1'b0, w_payload} < c_DEPTH;
    assign w_do_write = ~rst & w_accept & (w_cmd == c_CMD_WR_DATA) & r_wr_vld;
    assign w_do_read  = w_accept & (w_cmd == c_CMD_RD_DATA) & r_rd_vld;

    assign w_wr_addr_inc = (r_wr_addr == c_LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
    assign w_rd_addr_inc = (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + 1'b1;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid_d <= 1'b1;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_vld     <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_dout       <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_rx_valid_d <= rx_valid;
            if (w_accept) begin
                // Any accepted frame releases a pending read unless it is a new read.
                r_tx_valid <= w_do_read;
                case (w_cmd)
                    c_CMD_WR_ADDR: begin
                        if (w_addr_ok) begin
                            r_wr_addr <= w_payload[ADDR_SIZE-1:0];
                            r_wr_vld  <= 1'b1;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    c_CMD_WR_DATA: begin
                        if (r_wr_vld) begin
                            r_wr_addr <= w_wr_addr_inc;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    c_CMD_RD_ADDR: begin
                        if (w_addr_ok) begin
                            r_rd_addr <= w_payload[ADDR_SIZE-1:0];
                            r_rd_vld  <= 1'b1;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (r_rd_vld) begin
                            r_dout    <= r_mem[r_rd_addr];
                            r_rd_addr <= w_rd_addr_inc;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram
//  Purpose  : Self-checking bench for spi_ram against a frame-level model.
//  Revision : 1.0
// ============================================================================
module tb_spi_ram;

    localparam int M_DEPTH = 256;

    logic       clk;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;
    logic [7:0] dout2;
    logic       tx_valid2;
    logic       cmd_err2;

    int n_checks;
    int n_fail;

    // Frame-level reference model of the 256-deep instance
    logic [7:0] m_mem [M_DEPTH];
    int         m_wr_addr;
    int         m_rd_addr;
    bit         m_wr_vld;
    bit         m_rd_vld;
    logic [7:0] m_dout;
    bit         m_tx;
    bit         m_err;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut200 (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout2),
        .tx_valid (tx_valid2),
        .cmd_err  (cmd_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_addr = 0;
        m_rd_addr = 0;
        m_wr_vld  = 0;
        m_rd_vld  = 0;
        m_dout    = 8'h00;
        m_tx      = 0;
        m_err     = 0;
    endtask

    task automatic model_accept(input logic [1:0] cmd, input logic [7:0] pl);
        m_tx = 0;
        case (cmd)
            2'b00: if (int'(pl) < M_DEPTH) begin m_wr_addr = int'(pl); m_wr_vld = 1; end
                   else m_err = 1;
            2'b01: if (m_wr_vld) begin
                       m_mem[m_wr_addr] = pl;
                       m_wr_addr = (m_wr_addr + 1) % M_DEPTH;
                   end else m_err = 1;
            2'b10: if (int'(pl) < M_DEPTH) begin m_rd_addr = int'(pl); m_rd_vld = 1; end
                   else m_err = 1;
            default: if (m_rd_vld) begin
                         m_dout = m_mem[m_rd_addr];
                         m_tx = 1;
                         m_rd_addr = (m_rd_addr + 1) % M_DEPTH;
                     end else m_err = 1;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".tx_valid"}, tx_valid, m_tx);
        chk({tag, ".cmd_err"}, cmd_err, m_err);
    endtask

    // Raise rx_valid for 'hold' cycles, then leave it low for one cycle.
    task automatic send(input logic [1:0] cmd, input logic [7:0] pl, input int hold);
        @(negedge clk);
        din      = {cmd, pl};
        rx_valid = 1'b1;
        model_accept(cmd, pl);
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        check_outputs($sformatf("frame_%0d_%02h", cmd, pl));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        model_reset();

        // Reset state, then a read before any address load
        do_reset();
        check_outputs("reset");
        send(2'b11, 8'h00, 1);
        chk("early_read_err", cmd_err, 1'b1);

        // Single write and read-back
        do_reset();
        send(2'b00, 8'h12, 1);
        send(2'b01, 8'hA5, 1);
        send(2'b10, 8'h12, 1);
        send(2'b11, 8'h00, 1);
        chk("single_rd_data", dout, 8'hA5);
        chk("single_rd_tx", tx_valid, 1'b1);

        // Level hold: a 12-cycle frame writes exactly once
        send(2'b00, 8'h41, 1);
        send(2'b01, 8'hE1, 1);
        send(2'b01, 8'hE2, 1);
        send(2'b00, 8'h40, 1);
        send(2'b01, 8'h3C, 12);
        send(2'b10, 8'h40, 1);
        send(2'b11, 8'h00, 1);
        chk("hold_mem40", dout, 8'h3C);
        send(2'b11, 8'h00, 1);
        chk("hold_mem41", dout, 8'hE1);
        send(2'b11, 8'h00, 1);
        send(2'b01, 8'h99, 1);
        send(2'b10, 8'h41, 1);
        send(2'b11, 8'h00, 1);
        chk("hold_wr_addr41", dout, 8'h99);

        // Burst across the top of memory
        send(2'b00, 8'hFF, 1);
        send(2'b01, 8'h11, 2);
        send(2'b01, 8'h22, 1);
        send(2'b10, 8'hFF, 1);
        send(2'b11, 8'h5A, 1);
        chk("wrap_rd0", dout, 8'h11);
        send(2'b11, 8'h00, 3);
        chk("wrap_rd1", dout, 8'h22);
        send(2'b01, 8'h33, 1);
        send(2'b11, 8'h00, 1);
        chk("wrap_end_addr", dout, 8'h33);

        // tx_valid released by the next accepted frame
        send(2'b00, 8'h05, 1);
        send(2'b01, 8'h5A, 1);
        send(2'b10, 8'h05, 1);
        send(2'b11, 8'h00, 1);
        chk("txrel_set", tx_valid, 1'b1);
        send(2'b00, 8'h07, 1);
        chk("txrel_clr", tx_valid, 1'b0);
        chk("txrel_dout_stable", dout, 8'h5A);

        // Out-of-range load on a 200-deep instance
        do_reset();
        send(2'b00, 8'h05, 1);
        chk("oor_ok_load", cmd_err2, 1'b0);
        send(2'b00, 8'hC8, 1);
        chk("oor_err", cmd_err2, 1'b1);
        send(2'b01, 8'h77, 1);
        send(2'b10, 8'h05, 1);
        send(2'b11, 8'h00, 1);
        chk("oor_wr_addr_kept", dout2, 8'h77);
        chk("oor_rd_tx", tx_valid2, 1'b1);
        do_reset();
        chk("oor_reset_err", cmd_err2, 1'b0);
        send(2'b01, 8'h55, 1);
        chk("oor_wr_no_load", cmd_err2, 1'b1);

        // Level held through reset is ignored until it toggles
        do_reset();
        @(negedge clk);
        din      = {2'b11, 8'h00};
        rx_valid = 1'b1;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_hold_no_accept_err", cmd_err, 1'b0);
        chk("rst_hold_no_accept_tx", tx_valid, 1'b0);
        rx_valid = 1'b0;
        @(negedge clk);
        send(2'b11, 8'h00, 1);
        chk("rst_hold_toggle_accept", cmd_err, 1'b1);

        // Randomized traffic over a fully written memory
        do_reset();
        send(2'b00, 8'h00, 1);
        for (int i = 0; i < M_DEPTH; i++) begin
            send(2'b01, 8'($urandom), 1);
        end
        for (int i = 0; i < 200; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_ram.md
# spi_ram

Command-decoding single-port memory that sits directly downstream of the SPI slave and closes the loop back to it. Consumes each 10-bit frame the slave assembles (`din`/`rx_valid`), decodes the 2-bit command, and performs address load, write, or read. Read data returns on `dout`/`tx_valid`, which the slave shifts out on MISO. Address registers auto-increment to support burst transfers. A sticky error flag marks out-of-order or out-of-range commands.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; legal addresses are 0..MEM_DEPTH-1.
- `ADDR_SIZE`, 8: address register width; must satisfy 2^ADDR_SIZE >= MEM_DEPTH and ADDR_SIZE <= 8.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `din` input 10: frame from the SPI slave. `din[9:8]` is the command; `din[7:0]` is the payload.
- `rx_valid` input 1: frame valid. It is a level that stays high for many cycles per frame.
- `dout` output 8: read data, to the slave's tx_data.
- `tx_valid` output 1: `dout` holds valid read data.
- `cmd_err` output 1: sticky protocol/range error.

## Operation
- **Frame acceptance**
  - `rx_valid_d` is a registered copy of `rx_valid`.
  - A frame is accepted only in a cycle where `rx_valid`=1 and `rx_valid_d`=0.
  - Exactly one accept happens per high level, however long it lasts.
  - No accept occurs while `rx_valid` stays high.
- **Internal state**
  - `wr_addr`, `rd_addr` (ADDR_SIZE bits each).
  - `wr_vld`, `rd_vld` flags.
  - `mem[MEM_DEPTH]`.
- **Command 00, write address**
  - Payload < MEM_DEPTH: `wr_addr` <= payload, `wr_vld` <= 1.
  - Otherwise: `cmd_err` <= 1, and `wr_addr` and `wr_vld` are unchanged.
- **Command 01, write data**
  - `wr_vld`=1: `mem[wr_addr]` <= payload, and `wr_addr` <= `wr_addr`+1.
    - Wrap: MEM_DEPTH-1 -> 0.
  - `wr_vld`=0: `cmd_err` <= 1, no write.
- **Command 10, read address**
  - Same rules as command 00, applied to `rd_addr` and `rd_vld`.
- **Command 11, read data**
  - `rd_vld`=1: `dout` <= `mem[rd_addr]`, `tx_valid` <= 1, and `rd_addr` <= `rd_addr`+1 with the same wrap.
    - The payload is ignored.
  - `rd_vld`=0: `cmd_err` <= 1, `dout` unchanged, `tx_valid` <= 0.
- **tx_valid hold**
  - `tx_valid`, once set, holds with `dout` stable until the next accepted frame of any command.
  - On that next accept, `tx_valid` clears in the same edge, unless that frame is itself a successful read.
- **cmd_err**
  - Stays at 1 until `rst`.
  - Errored commands have no other side effect.
- **Concurrency**
  - At most one command per cycle, so there are no read/write port conflicts.
  - Write and read address spaces are independent.

## Timing
- **Reset** (rst=1 at an edge): at the next edge the block takes these values.
  - Outputs: `dout`=8'h00, `tx_valid`=0, `cmd_err`=0.
  - Internal: `wr_addr`=`rd_addr`=0, `wr_vld`=`rd_vld`=0, `rx_valid_d`=1.
  - Memory contents are not reset.
- **Reset mid-operation**
  - Reset has priority over an accept in the same cycle.
  - Because `rx_valid_d` resets to 1, an `rx_valid` level held through reset release is not accepted. It must drop low and rise again.
- **Accept point:** the accept condition is evaluated in cycle N, and every register update it causes occurs at the edge ending cycle N.
- **Read latency**
  - `dout` and `tx_valid` are valid one clock after the accept cycle.
  - They are registered; there is no combinational path from `din` or `rx_valid` to any output.
- **Write visibility:** a location written at accept N is readable by a command-11 accept at N+1 or later.
- **Burst throughput:** back-to-back frames need `rx_valid` low for at least 1 cycle between them, so the minimum accept spacing is 2 cycles.

## Test plan
- **Reset state:** `rst` 1 cycle -> `dout`=0, `tx_valid`=0, `cmd_err`=0. Then frame 3'b11 before any address load -> `cmd_err`=1, `tx_valid`=0.
- **Single write and read:**
  - Stimulus: frames {00,0x12}, {01,0xA5}, {10,0x12}, {11,0x00}.
  - Response: `dout`=0xA5 with `tx_valid`=1 one cycle after the 4th accept; `cmd_err`=0.
- **Level hold:** frame {01,0x3C} with `rx_valid` high for 12 cycles after {00,0x40} -> exactly one write. `mem[0x40]`=0x3C, `mem[0x41]` unchanged, `wr_addr`=0x41.
- **Burst with wrap:**
  - Stimulus: {00,0xFF}, then {01,0x11}, {01,0x22}; then {10,0xFF}, {11}, {11}.
  - Response: reads return 0x11 then 0x22; `rd_addr` and `wr_addr` wrap to 0x00 and end at 0x01.
- **Out-of-range address:** MEM_DEPTH=200, frame {00,0xC8} -> `cmd_err`=1 and `wr_addr` unchanged. A following {01,0x55} still errors if there has been no prior valid load.
- **tx_valid release and reset:**
  - {10,0x05},{11} -> `tx_valid`=1. A subsequent {00,0x07} accept -> `tx_valid`=0 on the next edge.
  - `rst` asserted while `rx_valid` held high, then deasserted -> no accept until `rx_valid` toggles low then high.
